glitch_sequencer: RTL and testbench

- Parametrised clock-glitch sequencer; generalises the single-condition glitch clock mux.
- On a synchronised trigger edge, waits a programmable delay, then emits a programmable train of glitch windows (width, gap, count).
- During each window, `glitched_clk` is switched from `clk_in1` to `clk_b`.
- Sits between the UART command/config registers and the target clock output.

---
 rtl/glitch_sequencer.sv | 167 ++++++++++++++++
 tb/tb_glitch_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sequencer.sv
// Clock-glitch sequencer: after a synchronised trigger edge and a programmable
// delay, swaps the target clock for clk_b during a train of glitch windows.
module glitch_sequencer #(
   parameter int DLY_W       = 16,
   parameter int PW_W        = 8,
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_in1,
   input  logic             rst_n,
   input  logic             clk_b,
   input  logic             trigger,
   input  logic             arm,
   input  logic             abort,
   input  logic             auto_rearm,
   input  logic [DLY_W-1:0] cfg_delay,
   input  logic [PW_W-1:0]  cfg_width,
   input  logic [PW_W-1:0]  cfg_gap,
   input  logic [CNT_W-1:0] cfg_count,
   output logic             glitch_en,
   output logic             glitched_clk,
   output logic             armed,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulse_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      DELAY,
      PULSE,
      GAP,
      DONE
   } state_t;

   state_t state;

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_d;
   logic                   trig_edge;

   logic [DLY_W-1:0] sh_delay;
   logic [PW_W-1:0]  sh_width;
   logic [PW_W-1:0]  sh_gap;
   logic [CNT_W-1:0] sh_count;

   logic [DLY_W-1:0] dly_cnt;
   logic [PW_W-1:0]  pw_cnt;
   logic [CNT_W-1:0] pc_inc;

   assign trig_edge = sync[SYNC_STAGES-1] & ~sync_d;

   // Saturating window count, used both for the register and the exit test.
   assign pc_inc = (pulse_cnt == {CNT_W{1'b1}}) ?
                   pulse_cnt : pulse_cnt + CNT_W'(1);

   // Deliberately glitchy: the whole point is to corrupt the target clock.
   assign glitched_clk = glitch_en ? clk_b : clk_in1;

   always_ff @(posedge clk_in1 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sync      <= '0;
         sync_d    <= 1'b0;
         sh_delay  <= '0;
         sh_width  <= '0;
         sh_gap    <= '0;
         sh_count  <= '0;
         dly_cnt   <= '0;
         pw_cnt    <= '0;
         pulse_cnt <= '0;
         glitch_en <= 1'b0;
         armed     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], trigger};
         sync_d <= sync[SYNC_STAGES-1];
         done   <= 1'b0;
         if (abort) begin
            state     <= IDLE;
            glitch_en <= 1'b0;
            armed     <= 1'b0;
            busy      <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (arm) begin
                     sh_delay  <= cfg_delay;
                     sh_width  <= (cfg_width == '0) ? PW_W'(1) : cfg_width;
                     sh_gap    <= (cfg_gap == '0) ? PW_W'(1) : cfg_gap;
                     sh_count  <= (cfg_count == '0) ? CNT_W'(1) : cfg_count;
                     pulse_cnt <= '0;
                     armed     <= 1'b1;
                     state     <= ARMED;
                  end
               end
               ARMED: begin
                  if (trig_edge) begin
                     armed <= 1'b0;
                     busy  <= 1'b1;
                     if (sh_delay == '0) begin
                        state     <= PULSE;
                        glitch_en <= 1'b1;
                        pw_cnt    <= sh_width - PW_W'(1);
                     end else begin
                        state   <= DELAY;
                        dly_cnt <= sh_delay - DLY_W'(1);
                     end
                  end
               end
               DELAY: begin
                  if (dly_cnt == '0) begin
                     state     <= PULSE;
                     glitch_en <= 1'b1;
                     pw_cnt    <= sh_width - PW_W'(1);
                  end else begin
                     dly_cnt <= dly_cnt - DLY_W'(1);
                  end
               end
               PULSE: begin
                  if (pw_cnt == '0) begin
                     pulse_cnt <= pc_inc;
                     glitch_en <= 1'b0;
                     if (pc_inc < sh_count) begin
                        state  <= GAP;
                        pw_cnt <= sh_gap - PW_W'(1);
                     end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     pw_cnt <= pw_cnt - PW_W'(1);
                  end
               end
               GAP: begin
                  if (pw_cnt == '0) begin
                     state     <= PULSE;
                     glitch_en <= 1'b1;
                     pw_cnt    <= sh_width - PW_W'(1);
                  end else begin
                     pw_cnt <= pw_cnt - PW_W'(1);
                  end
               end
               DONE: begin
                  if (auto_rearm) begin
                     state     <= ARMED;
                     armed     <= 1'b1;
                     pulse_cnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
               default: begin
                  state     <= IDLE;
                  glitch_en <= 1'b0;
                  armed     <= 1'b0;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: table of trains plus hand-written
// sequences for reset, abort, auto-rearm and arm-while-busy.
module tb_glitch_sequencer;

   logic        clk_in1 = 1'b0;
   logic        clk_b = 1'b0;
   logic        rst_n = 1'b0;
   logic        trigger = 1'b0;
   logic        arm = 1'b0;
   logic        abort = 1'b0;
   logic        auto_rearm = 1'b0;
   logic [15:0] cfg_delay = '0;
   logic [7:0]  cfg_width = '0;
   logic [7:0]  cfg_gap = '0;
   logic [7:0]  cfg_count = '0;
   logic        glitch_en;
   logic        glitched_clk;
   logic        armed;
   logic        busy;
   logic        done;
   logic [7:0]  pulse_cnt;

   int checks = 0;
   int errors = 0;

   int r_first, r_high, r_rises, r_done_e, r_done_n, r_armed_after;
   int mux_bad;

   typedef struct {
      int d, w, g, n;
      int first, high, rises, done_e, pc;
   } vec_t;

   vec_t vt[4];

   always #5 clk_in1 = ~clk_in1;
   always #2 clk_b = ~clk_b;

   glitch_sequencer dut (
      .clk_in1     (clk_in1),
      .rst_n       (rst_n),
      .clk_b       (clk_b),
      .trigger     (trigger),
      .arm         (arm),
      .abort       (abort),
      .auto_rearm  (auto_rearm),
      .cfg_delay   (cfg_delay),
      .cfg_width   (cfg_width),
      .cfg_gap     (cfg_gap),
      .cfg_count   (cfg_count),
      .glitch_en   (glitch_en),
      .glitched_clk(glitched_clk),
      .armed       (armed),
      .busy        (busy),
      .done        (done),
      .pulse_cnt   (pulse_cnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk_in1);
   endtask

   task automatic do_arm(input int d, input int w, input int g, input int n);
      @(negedge clk_in1);
      cfg_delay = 16'(d);
      cfg_width = 8'(w);
      cfg_gap   = 8'(g);
      cfg_count = 8'(n);
      arm = 1'b1;
      @(negedge clk_in1);
      arm = 1'b0;
   endtask

   // Raise trigger, then sample once per cycle (edge e = e-th posedge).
   // Cycle T (trig_edge) is sampled after edge 2.
   // mode 1: extra edge during DELAY, 2: arm mid-train, 3: abort at 2nd window
   task automatic fire(input int ncyc, input int mode);
      logic prev;
      prev = 1'b0;
      r_first = -1;
      r_high = 0;
      r_rises = 0;
      r_done_e = -1;
      r_done_n = 0;
      r_armed_after = -1;
      mux_bad = 0;
      trigger = 1'b1;
      for (int e = 1; e <= ncyc; e++) begin
         @(posedge clk_in1);
         @(negedge clk_in1);
         abort = 1'b0;
         arm = 1'b0;
         if (glitched_clk !== (glitch_en ? clk_b : clk_in1)) mux_bad++;
         if (glitch_en) begin
            r_high++;
            if (!prev) begin
               r_rises++;
               if (r_first < 0) r_first = e;
               if (mode == 3 && r_rises == 2) abort = 1'b1;
            end
         end
         prev = glitch_en;
         if (done) begin
            r_done_n++;
            if (r_done_e < 0) r_done_e = e;
         end
         if (r_done_e > 0 && e == r_done_e + 1) r_armed_after = int'(armed);
         if (mode == 1 && e == 1) trigger = 1'b0;
         if (mode == 1 && e == 2) trigger = 1'b1;
         if (mode == 2 && e == 4) begin
            cfg_width = 8'd1;
            cfg_gap   = 8'd1;
            cfg_count = 8'd1;
            arm = 1'b1;
         end
      end
      trigger = 1'b0;
   endtask

   initial begin
      vt[0] = '{d:5, w:3, g:2, n:3, first:8, high:9, rises:3, done_e:21, pc:3};
      vt[1] = '{d:0, w:0, g:0, n:0, first:3, high:1, rises:1, done_e:4, pc:1};
      vt[2] = '{d:2, w:1, g:0, n:2, first:5, high:2, rises:2, done_e:8, pc:2};
      vt[3] = '{d:1, w:4, g:3, n:2, first:4, high:8, rises:2, done_e:15, pc:2};

      idle_cycles(3);
      chk("reset_outputs", int'({glitch_en, armed, busy, done, pulse_cnt}), 0);
      rst_n = 1'b1;
      idle_cycles(4);

      for (int i = 0; i < 4; i++) begin
         do_arm(vt[i].d, vt[i].w, vt[i].g, vt[i].n);
         chk($sformatf("v%0d_armed", i), int'(armed), 1);
         fire(30, 0);
         chk($sformatf("v%0d_first", i), r_first, vt[i].first);
         chk($sformatf("v%0d_high", i), r_high, vt[i].high);
         chk($sformatf("v%0d_rises", i), r_rises, vt[i].rises);
         chk($sformatf("v%0d_done_at", i), r_done_e, vt[i].done_e);
         chk($sformatf("v%0d_done_n", i), r_done_n, 1);
         chk($sformatf("v%0d_pcnt", i), int'(pulse_cnt), vt[i].pc);
         chk($sformatf("v%0d_mux", i), mux_bad, 0);
         chk($sformatf("v%0d_idle", i), int'({armed, busy}), 0);
         idle_cycles(4);
      end

      // Abort during the second of four windows
      do_arm(0, 3, 2, 4);
      fire(20, 3);
      chk("abort_high", r_high, 4);
      chk("abort_rises", r_rises, 2);
      chk("abort_no_done", r_done_n, 0);
      chk("abort_pcnt", int'(pulse_cnt), 1);
      chk("abort_idle", int'({armed, busy, glitch_en}), 0);

      // abort + arm together in IDLE: abort wins
      @(negedge clk_in1);
      abort = 1'b1;
      arm = 1'b1;
      @(negedge clk_in1);
      abort = 1'b0;
      arm = 1'b0;
      chk("abort_arm_armed", int'(armed), 0);
      chk("abort_arm_pcnt", int'(pulse_cnt), 1);
      idle_cycles(4);
      fire(10, 0);
      chk("idle_trig_ignored", r_rises, 0);
      idle_cycles(4);

      // Auto-rearm: two edges 50 cycles apart, third edge during DELAY
      auto_rearm = 1'b1;
      do_arm(2, 1, 0, 1);
      fire(40, 0);
      idle_cycles(10);
      chk("rearm1_first", r_first, 5);
      chk("rearm1_high", r_high, 1);
      chk("rearm1_done_at", r_done_e, 6);
      chk("rearm1_armed_after", r_armed_after, 1);
      fire(20, 1);
      chk("rearm2_first", r_first, 5);
      chk("rearm2_rises", r_rises, 1);
      chk("rearm2_done_n", r_done_n, 1);
      chk("rearm2_armed_after", r_armed_after, 1);
      chk("rearm2_pcnt", int'(pulse_cnt), 0);
      auto_rearm = 1'b0;
      @(negedge clk_in1);
      abort = 1'b1;
      @(negedge clk_in1);
      abort = 1'b0;
      idle_cycles(4);

      // arm while busy is ignored; next arm accepted from IDLE
      do_arm(0, 2, 2, 3);
      fire(20, 2);
      chk("busy_arm_high", r_high, 6);
      chk("busy_arm_rises", r_rises, 3);
      chk("busy_arm_done_at", r_done_e, 13);
      chk("busy_arm_pcnt", int'(pulse_cnt), 3);
      chk("busy_arm_after", r_armed_after, 0);
      idle_cycles(4);
      do_arm(0, 1, 1, 1);
      fire(10, 0);
      chk("new_arm_high", r_high, 1);
      chk("new_arm_done_at", r_done_e, 4);
      idle_cycles(4);

      // Asynchronous reset mid-PULSE
      do_arm(0, 8, 1, 1);
      trigger = 1'b1;
      begin
         int k;
         k = 0;
         while (!glitch_en && k < 10) begin
            @(negedge clk_in1);
            k++;
         end
         chk("rst_reach_pulse", int'(glitch_en), 1);
      end
      @(negedge clk_in1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_outs", int'({glitch_en, busy, armed, pulse_cnt}), 0);
      chk("rst_mux_follow", int'(glitched_clk === clk_in1), 1);
      @(negedge clk_in1);
      rst_n = 1'b1;
      trigger = 1'b0;
      idle_cycles(4);
      fire(10, 0);
      chk("rst_idle_rises", r_rises, 0);
      chk("rst_idle_armed", int'(armed), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
